line_sync_gen: RTL and testbench

//  Line-timing transmitter: drives HSYNC and a pixel-index stream that downstream
//  per-line pixel counters consume. Each line is an HSYNC pulse, an active window
//  of indexed pixels with valid/ready back-pressure, then a blanking gap. Runs

---
 rtl/line_sync_gen.sv | 135 +++++++++++++
 tb/tb_line_sync_gen.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/line_sync_gen.sv
// Line-timing transmitter: HSYNC pulse, indexed active window with valid/ready, blanking gap.
// Optional line counter output enabled by defining LINE_SYNC_GEN_LINE_CNT_EN.
module line_sync_gen #(
   parameter int DWIDTH     = 8,
   parameter int SYNC_LEN   = 2,
   parameter int FIRST_IDX  = 2,
   parameter int ACTIVE_LEN = 254,
   parameter int BLANK_LEN  = 4
`ifdef LINE_SYNC_GEN_LINE_CNT_EN
  ,parameter int LWIDTH     = 8
`endif
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              cont,
   input  logic              abort,
   output logic              hsync,
   output logic              pix_valid,
   input  logic              pix_ready,
   output logic [DWIDTH-1:0] pix_idx,
   output logic              line_done,
`ifdef LINE_SYNC_GEN_LINE_CNT_EN
   output logic              busy,
   output logic [LWIDTH-1:0] line_cnt
`else
   output logic              busy
`endif
);

   localparam int MAXLEN = (SYNC_LEN > BLANK_LEN) ? SYNC_LEN : BLANK_LEN;
   localparam int CW     = (MAXLEN > 1) ? $clog2(MAXLEN) : 1;
   localparam logic [DWIDTH-1:0] FIRST_V = DWIDTH'(FIRST_IDX);
   localparam logic [DWIDTH-1:0] LAST_V  = DWIDTH'(FIRST_IDX + ACTIVE_LEN - 1);
   localparam logic [CW-1:0]     SYNC_END  = CW'(SYNC_LEN - 1);
   localparam logic [CW-1:0]     BLANK_END = CW'(BLANK_LEN - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SYNC,
      S_ACTIVE,
      S_GAP
   } state_t;

   state_t            state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [DWIDTH-1:0] idx_q, idx_d;
   logic              accept;
   logic              last_pix;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      idx_d    = idx_q;
      accept   = (state_q == S_ACTIVE) && pix_ready;
      last_pix = (idx_q == LAST_V);
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_SYNC;
               cnt_d   = '0;
            end
         end
         S_SYNC: begin
            if (cnt_q == SYNC_END) begin
               state_d = S_ACTIVE;
               cnt_d   = '0;
               idx_d   = FIRST_V;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_ACTIVE: begin
            if (accept) begin
               if (last_pix) begin
                  state_d = S_GAP;
                  cnt_d   = '0;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end
         end
         S_GAP: begin
            if (cnt_q == BLANK_END) begin
               state_d = cont ? S_SYNC : S_IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
      endcase
      // abort overrides everything, including a start seen in IDLE
      if (abort) begin
         state_d = S_IDLE;
         cnt_d   = '0;
      end
   end

   assign hsync     = (state_q == S_SYNC);
   assign pix_valid = (state_q == S_ACTIVE);
   assign busy      = (state_q != S_IDLE);
   assign pix_idx   = idx_q;
   assign line_done = accept && last_pix;

`ifdef LINE_SYNC_GEN_LINE_CNT_EN
   logic [LWIDTH-1:0] line_cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         line_cnt_q <= '0;
      end else if (line_done) begin
         line_cnt_q <= line_cnt_q + 1'b1;
      end
   end

   assign line_cnt = line_cnt_q;
`endif

endmodule

// File: tb/tb_line_sync_gen.sv
// Directed self-checking bench for line_sync_gen with default parameters.
module tb_line_sync_gen;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic       cont = 1'b0;
   logic       abort = 1'b0;
   logic       pix_ready = 1'b1;
   logic       hsync, pix_valid, line_done, busy;
   logic [7:0] pix_idx;
`ifdef LINE_SYNC_GEN_LINE_CNT_EN
   logic [7:0] line_cnt;
`endif

   always #5 clk = ~clk;

   line_sync_gen dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .cont      (cont),
      .abort     (abort),
      .hsync     (hsync),
      .pix_valid (pix_valid),
      .pix_ready (pix_ready),
      .pix_idx   (pix_idx),
      .line_done (line_done),
`ifdef LINE_SYNC_GEN_LINE_CNT_EN
      .busy      (busy),
      .line_cnt  (line_cnt)
`else
      .busy      (busy)
`endif
   );

   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;
   int   rises[$];
   logic prev_hs;
   int   lds, busycnt, stall, sc, poked;
   bit   done, found;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step;
      @(negedge clk);
      cyc++;
   endtask

   initial begin
      // reset values
      repeat (2) step;
      chk("rst_hsync", hsync, 0);
      chk("rst_valid", pix_valid, 0);
      chk("rst_idx", pix_idx, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", line_done, 0);
`ifdef LINE_SYNC_GEN_LINE_CNT_EN
      chk("rst_line_cnt", line_cnt, 0);
`endif
      rst_n = 1'b1;
      step;

      // single line, no back-pressure
      start = 1'b1;
      step;
      start = 1'b0;
      chk("t1_hs1", hsync, 1);
      chk("t1_busy", busy, 1);
      chk("t1_sync_valid", pix_valid, 0);
      step;
      chk("t1_hs2", hsync, 1);
      for (int i = 0; i < 254; i++) begin
         step;
         chk("t1_valid", pix_valid, 1);
         chk("t1_idx", pix_idx, 32'(2 + i));
         chk("t1_done", line_done, (i == 253) ? 1 : 0);
         chk("t1_act_hs", hsync, 0);
      end
      for (int j = 0; j < 4; j++) begin
         step;
         chk("t1_gap_valid", pix_valid, 0);
         chk("t1_gap_hs", hsync, 0);
         chk("t1_gap_busy", busy, 1);
         chk("t1_gap_idx", pix_idx, 255);
         chk("t1_gap_done", line_done, 0);
      end
      step;
      chk("t1_idle_busy", busy, 0);
`ifdef LINE_SYNC_GEN_LINE_CNT_EN
      chk("t1_line_cnt", line_cnt, 1);
`endif

      // continuous mode, three lines
      start = 1'b1;
      cont = 1'b1;
      prev_hs = 1'b0;
      lds = 0;
      done = 1'b0;
      for (int k = 0; k < 1200; k++) begin
         step;
         if (k == 0) start = 1'b0;
         if (hsync && !prev_hs) begin
            rises.push_back(cyc);
            if (rises.size() == 3) cont = 1'b0;
         end
         prev_hs = hsync;
         if (line_done) lds++;
         if (!busy) begin
            done = 1'b1;
            break;
         end
      end
      chk("t2_timeout", done, 1);
      chk("t2_rises", rises.size(), 3);
      chk("t2_period1", rises[1] - rises[0], 260);
      chk("t2_period2", rises[2] - rises[1], 260);
      chk("t2_line_done", lds, 3);
`ifdef LINE_SYNC_GEN_LINE_CNT_EN
      chk("t2_line_cnt", line_cnt, 4);
`endif

      // back-pressure: ready low for 5 cycles while idx=10
      start = 1'b1;
      pix_ready = 1'b1;
      busycnt = 0;
      stall = 0;
      sc = 0;
      done = 1'b0;
      for (int k = 0; k < 1200; k++) begin
         step;
         if (k == 0) start = 1'b0;
         if (!busy) begin
            done = 1'b1;
            break;
         end
         busycnt++;
         case (stall)
            0: if (pix_valid && pix_idx == 8'd10) begin
                  pix_ready = 1'b0;
                  stall = 1;
               end
            1: begin
                  sc++;
                  chk("t3_hold_idx", pix_idx, 10);
                  chk("t3_hold_valid", pix_valid, 1);
                  if (sc == 5) begin
                     pix_ready = 1'b1;
                     stall = 2;
                  end
               end
            2: begin
                  chk("t3_resume_idx", pix_idx, 11);
                  stall = 3;
               end
            default: ;
         endcase
      end
      chk("t3_timeout", done, 1);
      chk("t3_stall_seen", stall, 3);
      chk("t3_line_len", busycnt, 265);

      // abort mid-line, then restart
      start = 1'b1;
      lds = 0;
      found = 1'b0;
      for (int k = 0; k < 1200; k++) begin
         step;
         if (k == 0) start = 1'b0;
         if (line_done) lds++;
         if (pix_valid && pix_idx == 8'd100) begin
            found = 1'b1;
            break;
         end
      end
      chk("t4_reach_100", found, 1);
      abort = 1'b1;
      step;
      abort = 1'b0;
      chk("t4_busy", busy, 0);
      chk("t4_valid", pix_valid, 0);
      chk("t4_hs", hsync, 0);
      chk("t4_done", line_done, 0);
      for (int k = 0; k < 3; k++) begin
         step;
         if (line_done) lds++;
         chk("t4_stay_idle", busy, 0);
      end
      chk("t4_no_line_done", lds, 0);
`ifdef LINE_SYNC_GEN_LINE_CNT_EN
      chk("t4_line_cnt", line_cnt, 5);
`endif
      start = 1'b1;
      step;
      start = 1'b0;
      chk("t4_restart_hs", hsync, 1);
      chk("t4_restart_busy", busy, 1);
      step;
      step;
      chk("t4_restart_valid", pix_valid, 1);
      chk("t4_restart_idx", pix_idx, 2);
      abort = 1'b1;
      step;
      abort = 1'b0;
      chk("t4_abort2_busy", busy, 0);

      // start+abort together in IDLE; start ignored during ACTIVE
      start = 1'b1;
      abort = 1'b1;
      step;
      start = 1'b0;
      abort = 1'b0;
      chk("t5_both_busy", busy, 0);
      chk("t5_both_hs", hsync, 0);
      step;
      chk("t5_both_busy2", busy, 0);
      start = 1'b1;
      busycnt = 0;
      lds = 0;
      poked = 0;
      done = 1'b0;
      for (int k = 0; k < 1200; k++) begin
         step;
         if (k == 0) start = 1'b0;
         if (!busy) begin
            done = 1'b1;
            break;
         end
         busycnt++;
         if (line_done) lds++;
         if (poked == 0 && pix_valid && pix_idx == 8'd50) begin
            start = 1'b1;
            poked = 1;
         end else if (poked == 1) begin
            start = 1'b0;
            poked = 2;
            chk("t5_idx_after_start", pix_idx, 51);
            chk("t5_hs_after_start", hsync, 0);
         end
      end
      chk("t5_timeout", done, 1);
      chk("t5_line_len", busycnt, 260);
      chk("t5_line_done", lds, 1);
      step;
      step;
      chk("t5_idle_after", busy, 0);
`ifdef LINE_SYNC_GEN_LINE_CNT_EN
      chk("t5_line_cnt", line_cnt, 6);
`endif

      // asynchronous reset in SYNC
      start = 1'b1;
      step;
      start = 1'b0;
      chk("t6_hs_before", hsync, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("t6_hs_async", hsync, 0);
      chk("t6_busy_async", busy, 0);
      chk("t6_valid_async", pix_valid, 0);
      chk("t6_idx_async", pix_idx, 0);
`ifdef LINE_SYNC_GEN_LINE_CNT_EN
      chk("t6_line_cnt_async", line_cnt, 0);
`endif
      step;
      rst_n = 1'b1;
      step;
      chk("t6_idle_after", busy, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
